// File: rtl/avalon_pio_bank.sv
// avalon_pio_bank
// Bank of Avalon-MM mapped parallel I/O channels:
//   - N_OUT read/write output words driven onto pio_out
//   - N_IN asynchronous input words, each synchronised, debounced and
//     edge-captured into sticky write-1-to-clear bits
//   - one registered level interrupt from the masked capture bits
//
// Ports
//   clk_clk            single clock; all logic is in this domain
//   reset_reset_n      asynchronous active-low reset
//   avs_address        word address (6 bits)
//   avs_read           read strobe
//   avs_write          write strobe
//   avs_writedata      write data
//   avs_byteenable     write byte lanes
//   avs_readdata       read data, registered
//   avs_readdatavalid  high for the single cycle after a read strobe
//   avs_waitrequest    always 0
//   pio_out            output channels, channel i at [i*DATA_W +: DATA_W]
//   pio_in             asynchronous input channels, same packing
//   irq                level interrupt
//
// Bus handshake: the slave never stalls (waitrequest is 0). A read or
// write is accepted in every cycle its strobe is high. Each accepted read
// returns data with readdatavalid high in exactly the following cycle, so
// reads may be issued back to back. A read and write in the same cycle
// return the pre-write contents.
//
// Register map (word addresses)
//   0x00+i  OUT[i]   RW, byte-lane masked
//   0x10+j  IN[j]    RO, debounced value
//   0x18+j  CAP[j]   write 1 to clear, byte-lane masked
//   0x20+j  MASK[j]  RW, byte-lane masked
//   anything else, or a channel index beyond N_OUT/N_IN, reads 0 and
//   ignores writes.

module avalon_pio_bank #(
  parameter int DATA_W          = 32,
  parameter int N_OUT           = 4,
  parameter int N_IN            = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 1
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [5:0]                avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [DATA_W-1:0]         avs_writedata,
  input  logic [DATA_W/8-1:0]       avs_byteenable,
  output logic [DATA_W-1:0]         avs_readdata,
  output logic                      avs_readdatavalid,
  output logic                      avs_waitrequest,
  output logic [N_OUT*DATA_W-1:0]   pio_out,
  input  logic [N_IN*DATA_W-1:0]    pio_in,
  output logic                      irq
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    (DEBOUNCE_CYCLES < 1) ? '0 : CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [5:0] OUT_BASE  = 6'h00;
  localparam logic [5:0] IN_BASE   = 6'h10;
  localparam logic [5:0] CAP_BASE  = 6'h18;
  localparam logic [5:0] MASK_BASE = 6'h20;

  assign avs_waitrequest = 1'b0;

  // Reset asserts asynchronously and is released on a clock edge, so every
  // flop below leaves reset in the same cycle.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rst_sync <= 2'b00;
    else                rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Byte-lane enables expanded to a bit mask.
  logic [DATA_W-1:0] be_mask;

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < NB; b++) begin
      be_mask[b*8 +: 8] = {8{avs_byteenable[b]}};
    end
  end

  logic [DATA_W-1:0] out_arr  [N_OUT];
  logic [DATA_W-1:0] in_arr   [N_IN];
  logic [DATA_W-1:0] cap_arr  [N_IN];
  logic [DATA_W-1:0] mask_arr [N_IN];

  // ---------------------------------------------------------------------
  // Output channels
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    logic [DATA_W-1:0] out_q;

    always_ff @(posedge clk_clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else if (avs_write && (avs_address == OUT_BASE + 6'(i))) begin
        out_q <= (out_q & ~be_mask) | (avs_writedata & be_mask);
      end
    end

    assign out_arr[i]                    = out_q;
    assign pio_out[i*DATA_W +: DATA_W]   = out_q;
  end

  // ---------------------------------------------------------------------
  // Input channels: synchroniser, debounce, edge capture, mask
  // ---------------------------------------------------------------------
  for (genvar j = 0; j < N_IN; j++) begin : g_in
    logic [DATA_W-1:0] sync_a;
    logic [DATA_W-1:0] sync_b;
    logic [DATA_W-1:0] in_q;
    logic [DATA_W-1:0] in_prev;
    logic [DATA_W-1:0] cap_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] edge_hit;
    logic [DATA_W-1:0] cap_clr;

    always_ff @(posedge clk_clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_a <= '0;
        sync_b <= '0;
      end else begin
        sync_a <= pio_in[j*DATA_W +: DATA_W];
        sync_b <= sync_a;
      end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) in_q <= '0;
        else        in_q <= sync_b;
      end
    end else begin : g_debounce
      logic [CNT_W-1:0] cnt;

      // The change test looks at the word about to enter sync_b, so the
      // counter restarts in the same cycle the synchronised word changes.
      always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt  <= '0;
          in_q <= '0;
        end else if (sync_a != sync_b) begin
          cnt <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end else begin
          in_q <= sync_b;
        end
      end
    end

    always_comb begin
      if (EDGE_MODE == 0)      edge_hit = in_q & ~in_prev;
      else if (EDGE_MODE == 1) edge_hit = ~in_q & in_prev;
      else                     edge_hit = in_q ^ in_prev;
    end

    always_comb begin
      cap_clr = '0;
      if (avs_write && (avs_address == CAP_BASE + 6'(j))) begin
        cap_clr = avs_writedata & be_mask;
      end
    end

    // in_prev starts at 0 after reset, so an input held high through reset
    // shows up as a rising edge once it has been debounced.
    // A new edge wins over a simultaneous clear of the same bit.
    always_ff @(posedge clk_clk or negedge rst_n) begin
      if (!rst_n) begin
        in_prev <= '0;
        cap_q   <= '0;
      end else begin
        in_prev <= in_q;
        cap_q   <= (cap_q & ~cap_clr) | edge_hit;
      end
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
      if (!rst_n) begin
        mask_q <= '0;
      end else if (avs_write && (avs_address == MASK_BASE + 6'(j))) begin
        mask_q <= (mask_q & ~be_mask) | (avs_writedata & be_mask);
      end
    end

    assign in_arr[j]   = in_q;
    assign cap_arr[j]  = cap_q;
    assign mask_arr[j] = mask_q;
  end

  // ---------------------------------------------------------------------
  // Read path: decode sampled in the read cycle, returned one cycle later
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (avs_address == OUT_BASE + 6'(i)) rd_val = out_arr[i];
    end
    for (int j = 0; j < N_IN; j++) begin
      if (avs_address == IN_BASE   + 6'(j)) rd_val = in_arr[j];
      if (avs_address == CAP_BASE  + 6'(j)) rd_val = cap_arr[j];
      if (avs_address == MASK_BASE + 6'(j)) rd_val = mask_arr[j];
    end
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_val;
    end
  end

  // ---------------------------------------------------------------------
  // Interrupt
  // ---------------------------------------------------------------------
  logic irq_term;

  always_comb begin
    irq_term = 1'b0;
    for (int j = 0; j < N_IN; j++) begin
      irq_term = irq_term | (|(cap_arr[j] & mask_arr[j]));
    end
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= irq_term;
  end

endmodule

// File: tb/tb_avalon_pio_bank.sv
// Directed bench for avalon_pio_bank (DEBOUNCE_CYCLES=4, falling-edge
// capture). Reads push their expected data onto exp_q when issued; a
// monitor pops and compares whenever readdatavalid is seen.

module tb_avalon_pio_bank;

  localparam int DATA_W = 32;
  localparam int N_OUT  = 4;
  localparam int N_IN   = 2;
  localparam int DEB    = 4;
  localparam int EDGE   = 1;

  logic                    clk_clk;
  logic                    reset_reset_n;
  logic [5:0]              avs_address;
  logic                    avs_read;
  logic                    avs_write;
  logic [DATA_W-1:0]       avs_writedata;
  logic [DATA_W/8-1:0]     avs_byteenable;
  logic [DATA_W-1:0]       avs_readdata;
  logic                    avs_readdatavalid;
  logic                    avs_waitrequest;
  logic [N_OUT*DATA_W-1:0] pio_out;
  logic [N_IN*DATA_W-1:0]  pio_in;
  logic                    irq;

  avalon_pio_bank #(
    .DATA_W          (DATA_W),
    .N_OUT           (N_OUT),
    .N_IN            (N_IN),
    .DEBOUNCE_CYCLES (DEB),
    .EDGE_MODE       (EDGE)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .pio_out           (pio_out),
    .pio_in            (pio_in),
    .irq               (irq)
  );

  // ---------------- clock ----------------
  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0]       exp_q[$];
  logic [5:0]              addr_q[$];
  logic [N_OUT*DATA_W-1:0] exp_out;
  logic [DATA_W-1:0]       mon_exp;
  logic [5:0]              mon_addr;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] d,
                                               input logic [DATA_W/8-1:0] be);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  always @(negedge clk_clk) begin
    if (avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 1'b1, 1'b0);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_addr = addr_q.pop_front();
        check($sformatf("rd_%02h", mon_addr), avs_readdata, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [5:0] a, input logic [DATA_W-1:0] d, input logic [3:0] be);
    @(negedge clk_clk);
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    avs_read       = 1'b0;
    if (int'(a) < N_OUT) exp_out[int'(a)*DATA_W +: DATA_W] = merge(exp_out[int'(a)*DATA_W +: DATA_W], d, be);
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic rd_issue(input logic [5:0] a, input logic [DATA_W-1:0] e);
    @(negedge clk_clk);
    avs_read    = 1'b1;
    avs_write   = 1'b0;
    avs_address = a;
    exp_q.push_back(e);
    addr_q.push_back(a);
  endtask

  task automatic rd_end();
    @(negedge clk_clk);
    avs_read = 1'b0;
    #1;
    check("rd_latency", exp_q.size(), 0);
  endtask

  task automatic rd(input logic [5:0] a, input logic [DATA_W-1:0] e);
    rd_issue(a, e);
    rd_end();
  endtask

  task automatic rdwr(input logic [5:0] a, input logic [DATA_W-1:0] d,
                      input logic [3:0] be, input logic [DATA_W-1:0] e_old);
    @(negedge clk_clk);
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_read       = 1'b1;
    avs_write      = 1'b1;
    exp_q.push_back(e_old);
    addr_q.push_back(a);
    if (int'(a) < N_OUT) exp_out[int'(a)*DATA_W +: DATA_W] = merge(exp_out[int'(a)*DATA_W +: DATA_W], d, be);
    @(negedge clk_clk);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    #1;
    check("rdwr_latency", exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    avs_address    = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = '0;
    pio_in         = '0;
    exp_out        = '0;
    reset_reset_n  = 1'b1;
    #1 reset_reset_n = 1'b0;

    repeat (3) @(negedge clk_clk);
    check("rst_pio_out", pio_out, '0);
    check("rst_irq", irq, 1'b0);
    check("rst_rvalid", avs_readdatavalid, 1'b0);
    check("rst_rdata", avs_readdata, '0);
    check("rst_waitreq", avs_waitrequest, 1'b0);
    reset_reset_n = 1'b1;
    repeat (5) @(negedge clk_clk);

    // Byte-lane writes to OUT
    wr(6'h01, 32'h12345678, 4'b0101);
    check("out1_be0101", pio_out[63:32], 32'h00340078);
    check("out_others", pio_out, exp_out);
    wr(6'h00, 32'hA5A50001, 4'b1111);
    wr(6'h03, 32'hDEADBEEF, 4'b1010);
    check("out3_be1010", pio_out[127:96], 32'hDE00BE00);
    check("out_all", pio_out, exp_out);
    wr(6'h04, 32'hFFFFFFFF, 4'b1111);
    check("out_unmapped_wr", pio_out, exp_out);

    // Simultaneous read and write returns the pre-write value
    rdwr(6'h02, 32'h11223344, 4'b1111, 32'h0);
    check("out2_after_rdwr", pio_out[95:64], 32'h11223344);

    wr(6'h20, 32'h1, 4'b1111);
    wr(6'h22, 32'hFFFFFFFF, 4'b1111);

    // Back-to-back reads, including unmapped addresses
    rd_issue(6'h01, 32'h00340078);
    rd_issue(6'h03, 32'hDE00BE00);
    rd_issue(6'h04, 32'h0);
    rd_issue(6'h3F, 32'h0);
    rd_issue(6'h20, 32'h1);
    rd_issue(6'h22, 32'h0);
    rd_issue(6'h12, 32'h0);
    rd_issue(6'h1A, 32'h0);
    rd_issue(6'h02, 32'h11223344);
    rd_end();

    // Debounce: toggle bit 0 every 2 cycles, last toggle (to 1) at c=8;
    // IN[0] must read 1 only for reads sampled 6+ cycles after it.
    for (int c = 0; c < 18; c++) begin
      @(negedge clk_clk);
      if (c == 0 || c == 4 || c == 8) pio_in[0] = 1'b1;
      else if (c == 2 || c == 6)      pio_in[0] = 1'b0;
      avs_read    = 1'b1;
      avs_address = 6'h10;
      exp_q.push_back((c >= 14) ? 32'h1 : 32'h0);
      addr_q.push_back(6'h10);
    end
    rd_end();

    // Rising edge is not captured in falling mode
    rd(6'h18, 32'h0);
    check("irq_after_rise", irq, 1'b0);

    // Falling edge: IN falls 6 cycles after the input, CAP one later,
    // irq one after that.
    @(negedge clk_clk);
    pio_in[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_clk);
      check($sformatf("irq_fall_c%0d", k), irq, (k >= 8) ? 1'b1 : 1'b0);
    end
    rd(6'h18, 32'h1);

    // W1C clears CAP; irq follows one cycle later
    wr(6'h18, 32'h1, 4'b0001);
    check("irq_before_clear", irq, 1'b1);
    @(negedge clk_clk);
    check("irq_after_clear", irq, 1'b0);
    rd(6'h18, 32'h0);

    // Channel 1 bit 8: W1C gated by byte lanes; MASK[1]=0 keeps irq low
    @(negedge clk_clk);
    pio_in[DATA_W+8] = 1'b1;
    repeat (10) @(negedge clk_clk);
    pio_in[DATA_W+8] = 1'b0;
    repeat (10) @(negedge clk_clk);
    rd(6'h19, 32'h100);
    rd(6'h11, 32'h0);
    wr(6'h19, 32'h100, 4'b0001);
    rd(6'h19, 32'h100);
    wr(6'h19, 32'h100, 4'b0010);
    rd(6'h19, 32'h0);
    check("irq_ch1_unmasked", irq, 1'b0);

    // New edge in the same cycle as a W1C of that bit keeps it set
    @(negedge clk_clk);
    pio_in[0] = 1'b1;
    repeat (10) @(negedge clk_clk);
    rd(6'h18, 32'h0);
    rd(6'h10, 32'h1);
    @(negedge clk_clk);
    pio_in[0] = 1'b0;
    repeat (5) @(negedge clk_clk);
    wr(6'h18, 32'h1, 4'b1111);
    rd(6'h18, 32'h1);
    check("irq_w1c_race", irq, 1'b1);

    // Reset in the middle of a read stream
    rd_issue(6'h01, 32'h00340078);
    @(negedge clk_clk);
    check("pre_rst_pio_out", pio_out, exp_out);
    check("pre_rst_irq", irq, 1'b1);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b0;
    #1;
    check("midrst_rvalid", avs_readdatavalid, 1'b0);
    check("midrst_irq", irq, 1'b0);
    check("midrst_pio_out", pio_out, '0);
    avs_read = 1'b0;
    exp_out  = '0;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (5) @(negedge clk_clk);

    rd(6'h01, 32'h0);
    rd(6'h20, 32'h0);
    rd(6'h18, 32'h0);
    rd(6'h10, 32'h0);
    check("post_rst_pio_out", pio_out, exp_out);
    check("post_rst_irq", irq, 1'b0);

    repeat (2) @(negedge clk_clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_pio_bank.md
AVALON_PIO_BANK -- requirements
Module: avalon_pio_bank

Interface
REQ-001 Parameter DATA_W, default 32, data width of every channel and of the Avalon data bus; legal range 8..32 and a multiple of 8.
REQ-002 Parameter N_OUT, default 4, number of output channels; legal range 1..16.
REQ-003 Parameter N_IN, default 2, number of input channels; legal range 1..8.
REQ-004 Parameter DEBOUNCE_CYCLES, default 50000, stable-cycle count required before a debounced input updates; 0 = debounce bypassed.
REQ-005 Parameter EDGE_MODE, default 1, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = both.
REQ-006 clk_clk  input  1  single clock; all logic is in this domain.
REQ-007 reset_reset_n  input  1  asynchronous, active-low reset.
REQ-008 avs_address  input  6  word address.
REQ-009 avs_read  input  1  read strobe.
REQ-010 avs_write  input  1  write strobe.
REQ-011 avs_writedata  input  DATA_W  write data.
REQ-012 avs_byteenable  input  DATA_W/8  write byte lanes.
REQ-013 avs_readdata  output  DATA_W  read data.
REQ-014 avs_readdatavalid  output  1  read data valid.
REQ-015 avs_waitrequest  output  1  tied to 0.
REQ-016 pio_out  output  N_OUT*DATA_W  output channels, channel i in bits [i*DATA_W +: DATA_W].
REQ-017 pio_in  input  N_IN*DATA_W  asynchronous input channels, same packing.
REQ-018 irq  output  1  level interrupt.

Function
REQ-019 Register map (word addresses): 0x00+i = OUT[i] (RW); 0x10+j = IN[j] (RO, debounced value); 0x18+j = CAP[j] (write 1 to clear); 0x20+j = MASK[j] (RW).
REQ-020 Reads of unmapped addresses, including channel indices at or above N_OUT or N_IN, SHALL return 0; writes to such addresses SHALL be ignored.
REQ-021 Every read SHALL have a fixed latency of 1: readdatavalid is high for exactly the cycle after the avs_read cycle, and readdata holds the value sampled in the avs_read cycle.
REQ-022 Writes to OUT and MASK SHALL update only the byte lanes whose avs_byteenable bit is set, visible on pio_out the cycle after the write.
REQ-023 If avs_read and avs_write are asserted together, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-024 Each pio_in bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-025 Each input channel SHALL have one debounce counter: it resets to 0 on any change of the synchronised word, increments while the word is stable, and when it reaches DEBOUNCE_CYCLES-1 the debounced IN[j] loads the synchronised word and the counter saturates.
REQ-026 With DEBOUNCE_CYCLES=0, IN[j] SHALL equal the synchronised value, delayed by one register stage.
REQ-027 CAP[j] bit k SHALL set on the cycle IN[j] bit k shows the edge selected by EDGE_MODE, and SHALL hold until cleared.
REQ-028 A W1C write to CAP[j] SHALL clear the written 1 bits, gated by byteenable; if a new edge occurs on the same bit in the same cycle, the bit SHALL remain set.
REQ-029 irq SHALL be registered and SHALL equal the OR over all j of (CAP[j] & MASK[j]), one cycle after the term changes.
REQ-030 The counter width SHALL be clog2(DEBOUNCE_CYCLES+1), with a minimum of 1.

Reset
REQ-031 Reset SHALL be asserted asynchronously and released synchronously to clk_clk.
REQ-032 While reset_reset_n is 0: OUT, MASK, CAP, IN, synchronisers, counters, avs_readdata, avs_readdatavalid and irq SHALL all be 0.
REQ-033 Capture logic SHALL treat the IN value after reset as 0, so an input held at 1 through reset produces a rising edge once it is debounced.
REQ-034 A reset asserted mid-transaction SHALL abort any pending readdatavalid and SHALL discard any partially counted debounce.

Verification
REQ-035 Write 0x12345678 with byteenable 0b0101 to OUT[1] (previous value 0) -> pio_out channel 1 = 0x00340078 on the next cycle.
REQ-036 With DEBOUNCE_CYCLES=4, toggle pio_in[0] every 2 cycles, then hold it at 1 -> IN[0] bit 0 rises exactly 2+4 cycles after the last toggle, and not before.
REQ-037 With EDGE_MODE=1 and MASK[0]=0x1, drive a falling edge on bit 0 -> CAP[0]=0x1 and irq=1 one cycle later; write 0x1 to CAP[0] -> irq=0.
REQ-038 Issue a W1C to CAP[0] bit 0 in the same cycle a new edge sets that bit -> CAP[0] bit 0 stays 1.
REQ-039 Read address 0x3F and OUT[N_OUT] -> readdata = 0 and readdatavalid = 1 one cycle later; back-to-back reads produce back-to-back valids.
REQ-040 Assert reset_reset_n=0 during a read cycle -> readdatavalid, irq and pio_out go to 0 immediately, without waiting for a clock edge.
